serial_add_unit: RTL and testbench

Bit-serial adder stage that drives the gate-level full adder one bit per clock and consumes its sum/carry outputs. Accepts two WIDTH-bit operands plus carry-in on a start pulse, walks them LSB-first through the full-adder equations with a registered carry, and returns the WIDTH-bit sum and carry-out with a one-cycle done pulse. It is the sequential stage wrapped around the combinational full-adder cell, trading latency for area in multi-bit datapaths.

---
 rtl/serial_add_unit.sv | 140 ++++++++++++++
 tb/tb_serial_add_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_unit.sv
// Bit-serial adder: LSB-first full-adder walk with registered carry.
// Optional SERIAL_ADD_OVF_EN adds a signed-overflow output.
module serial_add_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             s, c;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  assign s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign c = (a_sr_q[0] & b_sr_q[0]) |
             (carry_q & (a_sr_q[0] ^ b_sr_q[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        sum_d   = {s, sum_q[WIDTH-1:1]};
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = c;
        if (cnt_q == LAST) begin
          // counter parks at the last index
          state_d = DONE;
          cout_d  = c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ c;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_unit.sv
// Bench for serial_add_unit: cycle model plus directed literal vectors.
// Define SERIAL_ADD_OVF_EN to also check ovf.
module tb_serial_add_unit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad = 0;

  serial_add_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a),
    .b(b),
    .cin(cin),
    .busy(busy),
    .done(done),
    .sum(sum),
    .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural model: an operation takes W edges,
  // its result is a+b+cin computed arithmetically.
  int           m_left = 0;
  logic         m_busy = 0, m_done = 0;
  logic [W-1:0] m_sum = 0, p_sum;
  logic         m_cout = 0, p_cout;
  logic         m_ovf = 0, p_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_busy = 0; m_done = 0;
      m_sum = 0; m_cout = 0; m_ovf = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1; m_busy = 0;
          m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
        end
      end else if (start) begin
        logic [W:0]   full;
        logic [W-1:0] low;
        full = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
        low  = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]}
               + W'(cin);
        p_sum = full[W-1:0];
        p_cout = full[W];
        p_ovf = low[W-1] ^ full[W];
        m_left = W; m_busy = 1;
        m_sum = 0; m_cout = 0; m_ovf = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    if (!m_busy) begin
      chk("sum", 32'(sum), 32'(m_sum));
      chk("cout", 32'(cout), 32'(m_cout));
`ifdef SERIAL_ADD_OVF_EN
      chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
    end
  end

  // Wait for done; returns edges elapsed since the start edge.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 3 * W) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(input logic [W-1:0] ta,
                     input logic [W-1:0] tb,
                     input logic tc,
                     input logic [W-1:0] es,
                     input logic ec,
                     input logic eo);
    int n;
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1;
    @(negedge clk);
    start = 0; a = ~ta; b = ~tb; cin = ~tc;
    wait_done(n);
    chk("latency", 32'(n), 32'(W));
    chk("lit_sum", 32'(sum), 32'(es));
    chk("lit_cout", 32'(cout), 32'(ec));
    chk("busy_at_done", 32'(busy), 32'(0));
`ifdef SERIAL_ADD_OVF_EN
    chk("lit_ovf", 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("eo unknown");
`endif
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'(0));
    chk("sum_held", 32'(sum), 32'(es));
  endtask

  initial begin
    int n;
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_sum", 32'(sum), 32'(0));
    repeat (2) @(negedge clk);
    #2 rst_n = 1;

    run(8'h00, 8'h00, 0, 8'h00, 0, 0);
    run(8'hFF, 8'h01, 0, 8'h00, 1, 0);
    run(8'h7F, 8'h01, 0, 8'h80, 0, 1);
    run(8'hA5, 8'h5A, 1, 8'h00, 1, 0);
    run(8'h80, 8'h80, 0, 8'h00, 1, 1);

    // start ignored while busy, then accepted in DONE
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1;
    @(negedge clk);
    start = 0;
    wait_done(n);
    chk("ign_lat", 32'(n), 32'(W - 3));
    chk("ign_sum", 32'(sum), 32'h46);
    chk("ign_cout", 32'(cout), 32'(0));
    a = 8'h01; b = 8'h02; cin = 0; start = 1;
    @(negedge clk);
    start = 0;
    chk("b2b_busy", 32'(busy), 32'(1));
    wait_done(n);
    chk("b2b_lat", 32'(n), 32'(W));
    chk("b2b_sum", 32'(sum), 32'h03);

    // reset mid-operation
    @(negedge clk);
    a = 8'hC3; b = 8'h3C; cin = 1; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_sum", 32'(sum), 32'(0));
    chk("abort_cout", 32'(cout), 32'(0));
`ifdef SERIAL_ADD_OVF_EN
    chk("abort_ovf", 32'(ovf), 32'(0));
`endif
    repeat (W + 2) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'(0));
    end
    #2 rst_n = 1;
    run(8'h0F, 8'hF0, 1, 8'h00, 1, 0);
    run(8'h64, 8'h32, 0, 8'h96, 0, 1);

    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      logic [W:0]   full;
      logic [W-1:0] low;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
      low  = {1'b0, ra[W-2:0]} + {1'b0, rb[W-2:0]} + W'(rc);
      run(ra, rb, rc, full[W-1:0], full[W],
          low[W-1] ^ full[W]);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
